division_sign_restore: RTL and testbench
========================================

Name: division_sign_restore

Overview:
- Back end of the signed 4-bit divider in the calculator datapath.
- The operand stage converts negative operands to magnitudes before the unsigned divide; this block does the reverse.
- It takes the unsigned quotient/remainder magnitudes plus the original operand signs and rebuilds two's-complement results.
- Negation is bit-serial through one ones'-complement-plus-carry cell, under a start/finish handshake, so it runs like the other multi-cycle calculator stages.

Parameters:
- WIDTH, 4, data width of magnitudes and signed results (must be ≥ 2).

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- restore_sel  input  1  start request, sampled only in IDLE.
- q_mag  input  WIDTH  unsigned quotient magnitude.
- r_mag  input  WIDTH  unsigned remainder magnitude.
- sign_a  input  1  dividend sign (1 = negative).
- sign_b  input  1  divisor sign (1 = negative).
- quotient  output  WIDTH  signed quotient, registered.
- remainder  output  WIDTH  signed remainder, registered.
- overflow  output  1  quotient not representable in WIDTH-bit two's complement, registered.
- busy  output  1  high in every state except IDLE.
- restore_finish  output  1  one-cycle completion pulse.

Behaviour:
- Reset: rst asynchronous, active-high; clock clk.
  - All outputs go to 0, state goes to IDLE, and the working registers and bit counter clear.
  - Reset mid-operation aborts; no finish pulse is produced.
- Sign rules:
  - q_neg = sign_a ^ sign_b.
  - r_neg = sign_a (truncating division: remainder takes the dividend's sign).
- IDLE:
  - On a clk edge with restore_sel=1: latch q_mag into qw and r_mag into rw; latch q_neg and r_neg; set cnt=0 and carry=1.
  - Latch ovf = (~q_neg & q_mag[W-1]) | (q_neg & q_mag[W-1] & |q_mag[W-2:0]).
  - Next state: NEG_Q if q_neg, else NEG_R if r_neg, else DONE.
- NEG_Q, one bit per cycle, LSB first:
  - bit = ~qw[0] ^ carry; carry <= ~qw[0] & carry.
  - qw <= {bit, qw[W-1:1]}; cnt++.
  - When cnt==W-1 the shift completes: reset cnt=0 and carry=1; next state is NEG_R if r_neg, else DONE.
- NEG_R: identical procedure on rw; after W cycles go to DONE.
- DONE:
  - quotient <= qw, remainder <= rw, overflow <= ovf, restore_finish <= 1.
  - Next state: IDLE. restore_finish returns to 0 on the following edge.
- Outputs hold their values until the next DONE or reset.
- Latency, counted from the edge that samples restore_sel to the edge that raises finish:
  - No negation: 2 edges.
  - One negation: 2+WIDTH edges.
  - Both negations: 2+2·WIDTH edges (10 for WIDTH=4).
- restore_sel while busy is ignored; it is not queued.
- restore_sel held high continuously: a new operation starts on the first IDLE edge after DONE.
- Negating a zero magnitude yields 0 with carry out discarded; this is legal.
- q_mag = 2^(W-1) with q_neg=1 yields the most negative value (1000 for W=4) with overflow=0.
- Overflow case: quotient still carries the raw bit-serial result; downstream logic qualifies it with overflow.

Optional Feature:
- Macro: SIGN_RESTORE_PARALLEL_EN.
- Defined: NEG_Q and NEG_R each take one cycle using full-width ~x+1. Latency becomes 2, 3, or 4 edges for zero, one, or two negations. Results, overflow and handshake are identical to the serial version.
- Undefined: bit-serial datapath as described under Behaviour; no full-width adder is instantiated.

Test Plan:
- Reset during NEG_Q (q_mag=3, sign_a=1, sign_b=0, rst at cycle 2) -> busy=0, quotient=0, no restore_finish pulse; a new start afterwards behaves normally.
- q_mag=2, r_mag=1, sign_a=0, sign_b=0, one-cycle restore_sel -> after 2 edges quotient=0010, remainder=0001, overflow=0, finish high one cycle.
- q_mag=3, r_mag=1, sign_a=1, sign_b=0 -> after 10 edges quotient=1101 (−3), remainder=1111 (−1), finish pulse.
- q_mag=2, r_mag=1, sign_a=1, sign_b=1 -> after 6 edges quotient=0010, remainder=1111; restore_sel pulsed while busy is ignored.
- q_mag=8, sign_a=0, sign_b=1 -> quotient=1000, overflow=0. q_mag=8, sign_a=1, sign_b=1 -> overflow=1, quotient=1000.
- Run the same vectors with SIGN_RESTORE_PARALLEL_EN defined -> identical results; latency 2/3/4 edges for zero/one/two negations.

Source files
------------

// File: rtl/division_sign_restore.sv
// Signed-result back end of the 4-bit divider: rebuilds two's-complement
// quotient/remainder from magnitudes. SIGN_RESTORE_PARALLEL_EN: one-cycle negate.
module division_sign_restore #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             restore_sel,
  input  logic [WIDTH-1:0] q_mag,
  input  logic [WIDTH-1:0] r_mag,
  input  logic             sign_a,
  input  logic             sign_b,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             overflow,
  output logic             busy,
  output logic             restore_finish
);

  typedef enum logic [1:0] {
    IDLE,
    NEG_Q,
    NEG_R,
    DONE
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] qw;
  logic [WIDTH-1:0] rw;
  logic             q_neg_l;
  logic             r_neg_l;
  logic             ovf;
  logic             q_neg;
  logic             ovf_in;

  assign q_neg  = sign_a ^ sign_b;
  assign ovf_in = q_mag[WIDTH-1] & (~q_neg | (|q_mag[WIDTH-2:0]));
  assign busy   = (state != IDLE);

`ifndef SIGN_RESTORE_PARALLEL_EN
  localparam int CW = $clog2(WIDTH);

  logic [CW-1:0] cnt;
  logic          carry;
  logic          src;
  logic          nbit;
  logic          last;

  // single shared ones'-complement-plus-carry cell
  assign src  = (state == NEG_R) ? rw[0] : qw[0];
  assign nbit = ~src ^ carry;
  assign last = (cnt == CW'(WIDTH - 1));
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      qw             <= '0;
      rw             <= '0;
      q_neg_l        <= 1'b0;
      r_neg_l        <= 1'b0;
      ovf            <= 1'b0;
      quotient       <= '0;
      remainder      <= '0;
      overflow       <= 1'b0;
      restore_finish <= 1'b0;
`ifndef SIGN_RESTORE_PARALLEL_EN
      cnt            <= '0;
      carry          <= 1'b0;
`endif
    end else begin
      restore_finish <= 1'b0;
      unique case (state)
        IDLE: begin
          if (restore_sel) begin
            qw      <= q_mag;
            rw      <= r_mag;
            q_neg_l <= q_neg;
            r_neg_l <= sign_a;
            ovf     <= ovf_in;
`ifndef SIGN_RESTORE_PARALLEL_EN
            cnt     <= '0;
            carry   <= 1'b1;
`endif
            if (q_neg)       state <= NEG_Q;
            else if (sign_a) state <= NEG_R;
            else             state <= DONE;
          end
        end
        NEG_Q: begin
`ifdef SIGN_RESTORE_PARALLEL_EN
          qw    <= ~qw + WIDTH'(1);
          state <= r_neg_l ? NEG_R : DONE;
`else
          qw    <= {nbit, qw[WIDTH-1:1]};
          carry <= ~qw[0] & carry;
          if (last) begin
            cnt   <= '0;
            carry <= 1'b1;
            state <= r_neg_l ? NEG_R : DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
`endif
        end
        NEG_R: begin
`ifdef SIGN_RESTORE_PARALLEL_EN
          rw    <= ~rw + WIDTH'(1);
          state <= DONE;
`else
          rw    <= {nbit, rw[WIDTH-1:1]};
          carry <= ~rw[0] & carry;
          if (last) begin
            cnt   <= '0;
            carry <= 1'b1;
            state <= DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
`endif
        end
        DONE: begin
          quotient       <= qw;
          remainder      <= rw;
          overflow       <= ovf;
          restore_finish <= 1'b1;
          state          <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // q_neg_l is only consulted through the state sequence chosen at start
  logic unused_ok;
  assign unused_ok = q_neg_l;

endmodule

// File: tb/tb_division_sign_restore.sv
// Directed bench for division_sign_restore: reset, abort, sign cases,
// overflow boundaries, latency and busy-time start rejection.
module tb_division_sign_restore;

  localparam int W = 4;
`ifdef SIGN_RESTORE_PARALLEL_EN
  localparam int L1 = 3;
  localparam int L2 = 4;
`else
  localparam int L1 = 2 + W;
  localparam int L2 = 2 + 2 * W;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         restore_sel = 1'b0;
  logic [W-1:0] q_mag = '0;
  logic [W-1:0] r_mag = '0;
  logic         sign_a = 1'b0;
  logic         sign_b = 1'b0;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         overflow;
  logic         busy;
  logic         restore_finish;

  int n_vec = 0;
  int n_err = 0;

  division_sign_restore #(.WIDTH(W)) dut (
    .clk(clk),
    .rst(rst),
    .restore_sel(restore_sel),
    .q_mag(q_mag),
    .r_mag(r_mag),
    .sign_a(sign_a),
    .sign_b(sign_b),
    .quotient(quotient),
    .remainder(remainder),
    .overflow(overflow),
    .busy(busy),
    .restore_finish(restore_finish)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic run(input logic [W-1:0] q, input logic [W-1:0] r,
                     input logic sa, input logic sb, input bit pulse,
                     output int lat);
    @(negedge clk);
    q_mag = q;
    r_mag = r;
    sign_a = sa;
    sign_b = sb;
    restore_sel = 1'b1;
    @(posedge clk);
    #1;
    restore_sel = 1'b0;
    lat = 1;
    while (restore_finish !== 1'b1 && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
      restore_sel = pulse && (lat == 2);
    end
    restore_sel = 1'b0;
  endtask

  task automatic after_done(input string tag);
    @(posedge clk);
    #1;
    chk({tag, "_fin_drop"}, 32'(restore_finish), 32'd0);
    chk({tag, "_idle"}, 32'(busy), 32'd0);
  endtask

  initial begin
    int lat;
    int seen;
    #2;
    chk("rst_q", 32'(quotient), 32'h0);
    chk("rst_r", 32'(remainder), 32'h0);
    chk("rst_ovf", 32'(overflow), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_fin", 32'(restore_finish), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // abort during quotient negation
    @(negedge clk);
    q_mag = 4'd3;
    r_mag = 4'd1;
    sign_a = 1'b1;
    sign_b = 1'b0;
    restore_sel = 1'b1;
    @(posedge clk);
    #1;
    restore_sel = 1'b0;
    chk("abort_busy_pre", 32'(busy), 32'd1);
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_q", 32'(quotient), 32'h0);
    chk("abort_fin", 32'(restore_finish), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    for (int i = 0; i < 15; i++) begin
      @(posedge clk);
      #1;
      if (restore_finish === 1'b1) seen++;
    end
    chk("abort_no_pulse", 32'(seen), 32'd0);

    run(4'd2, 4'd1, 1'b0, 1'b0, 1'b0, lat);
    chk("pp_lat", 32'(lat), 32'd2);
    chk("pp_q", 32'(quotient), 32'h2);
    chk("pp_r", 32'(remainder), 32'h1);
    chk("pp_ovf", 32'(overflow), 32'd0);
    after_done("pp");
    chk("pp_hold_q", 32'(quotient), 32'h2);

    run(4'd3, 4'd1, 1'b1, 1'b0, 1'b0, lat);
    chk("np_lat", 32'(lat), 32'(L2));
    chk("np_q", 32'(quotient), 32'hD);
    chk("np_r", 32'(remainder), 32'hF);
    chk("np_ovf", 32'(overflow), 32'd0);
    after_done("np");

    run(4'd2, 4'd1, 1'b1, 1'b1, 1'b1, lat);
    chk("nn_lat", 32'(lat), 32'(L1));
    chk("nn_q", 32'(quotient), 32'h2);
    chk("nn_r", 32'(remainder), 32'hF);
    after_done("nn");

    run(4'd8, 4'd0, 1'b0, 1'b1, 1'b0, lat);
    chk("min_lat", 32'(lat), 32'(L1));
    chk("min_q", 32'(quotient), 32'h8);
    chk("min_r", 32'(remainder), 32'h0);
    chk("min_ovf", 32'(overflow), 32'd0);
    after_done("min");

    run(4'd8, 4'd0, 1'b1, 1'b1, 1'b0, lat);
    chk("ovf_lat", 32'(lat), 32'(L1));
    chk("ovf_q", 32'(quotient), 32'h8);
    chk("ovf_r", 32'(remainder), 32'h0);
    chk("ovf_ovf", 32'(overflow), 32'd1);
    after_done("ovf");

    run(4'd5, 4'd3, 1'b0, 1'b1, 1'b0, lat);
    chk("pn_lat", 32'(lat), 32'(L1));
    chk("pn_q", 32'(quotient), 32'hB);
    chk("pn_r", 32'(remainder), 32'h3);
    chk("pn_ovf", 32'(overflow), 32'd0);

    run(4'd9, 4'd2, 1'b1, 1'b0, 1'b0, lat);
    chk("ovn_lat", 32'(lat), 32'(L2));
    chk("ovn_q", 32'(quotient), 32'h7);
    chk("ovn_r", 32'(remainder), 32'hE);
    chk("ovn_ovf", 32'(overflow), 32'd1);
    after_done("ovn");
    repeat (3) @(posedge clk);
    #1;
    chk("ovn_hold_q", 32'(quotient), 32'h7);
    chk("ovn_hold_r", 32'(remainder), 32'hE);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
